// File: rtl/exc_flush_sequencer.sv
// exc_flush_sequencer: sequences flush, CP0 update, fetch redirect and drain after an exception or ERET
// Ports: clk, rst (async, active-high); exc_req/exc_type/exc_inst_pc/exc_in_delayslot/eret_target
// from MEM; fetch_ready from IF; flush_o/stall_o to pipeline regs; redirect_valid/redirect_pc to IF;
// cp0_exc_we/cp0_epc_wdata/cp0_excode/cp0_bd/cp0_exl_clr to CP0; busy high outside IDLE.
// Optional: define EXC_STATS_EN to add a saturating exc_count[15:0] of non-ERET exceptions.
module exc_flush_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [4:0]  exc_type,
    input  logic [31:0] exc_inst_pc,
    input  logic        exc_in_delayslot,
    input  logic [31:0] eret_target,
    input  logic        fetch_ready,
    output logic        flush_o,
    output logic        stall_o,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        cp0_exc_we,
    output logic [31:0] cp0_epc_wdata,
    output logic [4:0]  cp0_excode,
    output logic        cp0_bd,
    output logic        cp0_exl_clr,
`ifdef EXC_STATS_EN
    output logic [15:0] exc_count,
`endif
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT, DRAIN} state_t;
    state_t      state;
    logic [31:0] tgt;
    logic [2:0]  cnt;
    logic        is_eret;
    logic        start;
    logic [4:0]  excode;
    logic [31:0] epc;
    assign is_eret = exc_type == 5'b00101;
    assign start   = state == IDLE && exc_req && exc_type != 5'b11111;
    // Types outside the listed set fall into the reserved class.
    always_comb begin
        excode = exc_type == 5'b00000 ? 5'h00 :
                 exc_type == 5'b00001 ? 5'h04 :
                 exc_type == 5'b00010 ? 5'h0C :
                 exc_type == 5'b00011 ? 5'h08 :
                 exc_type == 5'b00100 ? 5'h09 : 5'h0A;
        epc    = exc_in_delayslot ? exc_inst_pc - 32'd4 : exc_inst_pc;
    end
    // Outputs are computed one state ahead so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tgt            <= '0;
            cnt            <= '0;
            flush_o        <= 1'b0;
            stall_o        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            cp0_exc_we     <= 1'b0;
            cp0_epc_wdata  <= '0;
            cp0_excode     <= '0;
            cp0_bd         <= 1'b0;
            cp0_exl_clr    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state         <= FLUSH;
                    tgt           <= is_eret ? eret_target : EXC_VECTOR;
                    flush_o       <= 1'b1;
                    stall_o       <= 1'b1;
                    busy          <= 1'b1;
                    cp0_exc_we    <= !is_eret;
                    cp0_exl_clr   <= is_eret;
                    cp0_epc_wdata <= epc;
                    cp0_excode    <= excode;
                    cp0_bd        <= exc_in_delayslot;
                end
                FLUSH: begin
                    state          <= REDIRECT;
                    flush_o        <= 1'b0;
                    cp0_exc_we     <= 1'b0;
                    cp0_exl_clr    <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= tgt;
                end
                REDIRECT: if (fetch_ready) begin
                    state          <= DRAIN;
                    cnt            <= 3'(DRAIN_CYCLES);
                    redirect_valid <= 1'b0;
                    stall_o        <= 1'b0;
                    flush_o        <= 1'b1;
                end
                DRAIN: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef EXC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) exc_count <= '0;
        else if (start && !is_eret && exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
    end
`endif
endmodule

// File: doc/exc_flush_sequencer.md
Name: exc_flush_sequencer

Overview:
- Sequences pipeline recovery after the MEM-stage exception decision.
- Accepts one exception or ERET request and performs these steps in order:
  - flushes the pipeline;
  - pulses CP0 updates (EPC, Cause.BD, Cause.ExcCode, Status.EXL);
  - hands the redirect PC to fetch with a valid/ready handshake;
  - drains for a fixed number of cycles before re-arming.
- Sits between the exception-decision logic, the CP0 register file, the pipeline registers and the IF stage.

Parameters:
- DRAIN_CYCLES, 2, idle cycles after redirect acceptance before the next request is accepted (1..7).
- EXC_VECTOR, 32'hBFC00380, redirect target for every non-ERET exception.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- exc_req  in  1  exception/ERET request from the MEM stage (level; sampled only in IDLE).
- exc_type  in  5  type code:
  - 00000 interrupt
  - 00001 address error
  - 00010 overflow
  - 00011 syscall
  - 00100 break
  - 00101 eret
  - 10101, 10111 reserved-class
  - 11111 none
- exc_inst_pc  in  32  PC of the faulting instruction.
- exc_in_delayslot  in  1  faulting instruction is in a branch delay slot.
- eret_target  in  32  CP0 EPC value, used for ERET.
- fetch_ready  in  1  IF accepts the redirect.
- flush_o  out  1  clears all pipeline registers.
- stall_o  out  1  holds IF/ID while the sequencer is busy.
- redirect_valid  out  1  redirect offered to IF.
- redirect_pc  out  32  redirect target.
- cp0_exc_we  out  1  one-cycle strobe: write EPC/Cause and set Status.EXL.
- cp0_epc_wdata  out  32  EPC value to write.
- cp0_excode  out  5  Cause.ExcCode value.
- cp0_bd  out  1  Cause.BD value.
- cp0_exl_clr  out  1  one-cycle strobe: clear Status.EXL (ERET).
- busy  out  1  high in every state except IDLE.

Behaviour:
- State machine: IDLE, FLUSH, REDIRECT, DRAIN.
- Reset (asynchronous, rst=1), any state:
  - state goes to IDLE;
  - all outputs are 0, including redirect_pc, cp0_epc_wdata and cp0_excode;
  - drain counter is 0;
  - the captured request is discarded.
- IDLE:
  - exc_req=1 with exc_type != 11111: register type, PC, delay-slot flag and eret_target; go to FLUSH next cycle.
  - exc_req=1 with exc_type=11111: ignored, stay in IDLE.
- FLUSH (exactly 1 cycle):
  - flush_o=1, stall_o=1.
  - Non-ERET: cp0_exc_we=1.
    - cp0_bd = captured delay-slot flag.
    - cp0_epc_wdata = PC-4 if in delay slot, else PC. 32-bit wrap: 0 - 4 = FFFFFFFC.
    - cp0_excode mapping: interrupt 00h, address error 04h, overflow 0Ch, syscall 08h, break 09h, reserved-class 0Ah.
  - ERET: cp0_exl_clr=1; cp0_exc_we=0.
  - Next state: REDIRECT.
- REDIRECT:
  - redirect_valid=1, stall_o=1.
  - redirect_pc = EXC_VECTOR, or the captured eret_target for ERET.
  - redirect_pc is held stable until the cycle in which fetch_ready=1.
  - Transfer occurs on the clock edge where redirect_valid & fetch_ready.
  - After transfer: load the drain counter with DRAIN_CYCLES and go to DRAIN.
  - No timeout.
- DRAIN:
  - stall_o=0, flush_o=1 (squashes wrong-path fetches).
  - Counter decrements each cycle; at 1, go to IDLE.
  - Total DRAIN duration = DRAIN_CYCLES cycles.
- Timing and request handling:
  - Minimum request-to-IDLE latency: 1 (FLUSH) + 1 (REDIRECT with fetch_ready already high) + DRAIN_CYCLES.
  - exc_req while busy is ignored; that instruction is flushed.
  - exc_req arriving in the same cycle the FSM returns to IDLE is not sampled until the following cycle.
  - cp0_exc_we and cp0_exl_clr are never both high and are never high outside FLUSH.
- Outputs are registered (Moore); no combinational path from any input to any output.

Optional Feature:
- Macro: EXC_STATS_EN.
- Defined:
  - adds output exc_count [15:0], reset 0;
  - increments by 1 on every FLUSH entry for a non-ERET exception;
  - saturates at FFFFh.
- Undefined:
  - port absent, no counter logic;
  - all other behaviour identical.

Test Plan:
- Reset: assert rst mid-REDIRECT -> same cycle all outputs 0, busy=0; after release a new syscall sequences normally.
- Syscall at PC 8000_0100, not in delay slot, fetch_ready=1 -> next cycle:
  - cp0_exc_we=1, excode=08h, epc=8000_0100, bd=0, flush_o=1;
  - next cycle: redirect_valid with redirect_pc=BFC0_0380;
  - then 2 DRAIN cycles, then busy=0.
- Overflow in delay slot at PC 8000_0204 -> epc=8000_0200, bd=1, excode=0Ch.
- ERET with eret_target=8000_0400 -> cp0_exl_clr=1, cp0_exc_we=0, redirect_pc=8000_0400.
- Backpressure: fetch_ready low for 5 cycles -> redirect_valid high and redirect_pc stable for 6 cycles; DRAIN starts after the acceptance edge.
- Request while busy: second break during DRAIN -> ignored, no second cp0_exc_we; with EXC_STATS_EN, exc_count=1.
